mul_share_arbiter: RTL and testbench

- Shares one combinational 32x32 Karatsuba multiplier (karatsuba_32_gate) between NUM_REQ requesters, for example the FP multiply mantissa path and the divider iteration path.
- Round-robin arbitration with a valid/ready handshake on every requester.
- Two-stage registered pipeline: operand register, then product register.
- Returns the 64-bit product together with the ID of the requester that issued it.

---
 rtl/mul_share_pkg.sv | 17 +
 rtl/karatsuba_32_gate.sv | 35 +++
 rtl/rr_arbiter.sv | 33 +++
 rtl/mul_share_arbiter.sv | 125 ++++++++++++
 tb/tb_mul_share_arbiter.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_share_pkg.sv
// Shared constants and helpers for the multiplier-sharing arbiter slice.
package mul_share_pkg;

  localparam int unsigned MUL_W       = 32;
  localparam int unsigned PROD_W      = 64;
  localparam int unsigned NUM_REQ_DEF = 4;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned k = 0; k < 32; k++) begin
      if ((64'd1 << r) < 64'(n)) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/karatsuba_32_gate.sv
// Combinational 32x32 unsigned multiplier built from three 16/17-bit partial products.
module karatsuba_32_gate
  import mul_share_pkg::*;
(
  input  logic [MUL_W-1:0]  a,
  input  logic [MUL_W-1:0]  b,
  output logic [PROD_W-1:0] p
);

  localparam int unsigned H  = MUL_W / 2;
  localparam int unsigned HS = H + 1;
  localparam int unsigned W2 = 2 * H;
  localparam int unsigned WZ = 2 * H + 2;

  logic [H-1:0]  a_hi, a_lo, b_hi, b_lo;
  logic [HS-1:0] a_sum, b_sum;
  logic [W2-1:0] z2, z0;
  logic [WZ-1:0] zs, z1;

  always_comb begin
    a_hi  = a[MUL_W-1:H];
    a_lo  = a[H-1:0];
    b_hi  = b[MUL_W-1:H];
    b_lo  = b[H-1:0];
    a_sum = HS'(a_hi) + HS'(a_lo);
    b_sum = HS'(b_hi) + HS'(b_lo);
    z2    = W2'(a_hi) * W2'(b_hi);
    z0    = W2'(a_lo) * W2'(b_lo);
    zs    = WZ'(a_sum) * WZ'(b_sum);
    // Middle term is never negative: (ah+al)(bh+bl) >= ah*bh + al*bl.
    z1    = zs - WZ'(z2) - WZ'(z0);
    p     = {z2, z0} + (PROD_W'(z1) << H);
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter; the rotating pointer is owned by the parent.
module rr_arbiter
  import mul_share_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned ID_W    = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_idx
);

  always_comb begin
    logic            found;
    logic [ID_W-1:0] idx;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    // First asserted request at or after ptr, wrapping modulo NUM_REQ.
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((32'(ptr) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        found   = 1'b1;
        gnt_idx = idx;
      end
    end
    if (found && en) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one 32x32 multiplier with an issue register and an output register.
module mul_share_arbiter
  import mul_share_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned ID_W    = clog2(NUM_REQ),
  parameter int unsigned CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*MUL_W-1:0] req_a,
  input  logic [NUM_REQ*MUL_W-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [PROD_W-1:0]        rsp_p,
  output logic [ID_W-1:0]          rsp_id,
  output logic                     busy,
  output logic [CNT_W-1:0]         ops_done
);

  logic              s1_valid_q;
  logic [MUL_W-1:0]  s1_a_q, s1_b_q;
  logic [ID_W-1:0]   s1_id_q;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic              rsp_valid_q;
  logic [PROD_W-1:0] rsp_p_q;
  logic [ID_W-1:0]   rsp_id_q;
  logic [CNT_W-1:0]  ops_done_q;

  logic              s2_load, s1_adv, s1_free, accept;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]   gnt_idx;
  logic [MUL_W-1:0]  sel_a, sel_b;
  logic [PROD_W-1:0] prod;

  assign s2_load = !rsp_valid_q || rsp_ready;
  assign s1_adv  = s1_valid_q && s2_load;
  assign s1_free = !s1_valid_q || s2_load;

  // Grants are suppressed while reset is held so nothing looks accepted.
  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .en      (s1_free && rst_n),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign accept    = |gnt;

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_a = req_a[i*MUL_W +: MUL_W];
        sel_b = req_b[i*MUL_W +: MUL_W];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = (32'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + ID_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_id_q    <= '0;
      ptr_q      <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (accept) begin
        s1_valid_q <= 1'b1;
        s1_a_q     <= sel_a;
        s1_b_q     <= sel_b;
        s1_id_q    <= gnt_idx;
      end else if (s1_adv) begin
        s1_valid_q <= 1'b0;
      end
    end
  end

  karatsuba_32_gate u_mul (
    .a (s1_a_q),
    .b (s1_b_q),
    .p (prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_p_q     <= '0;
      rsp_id_q    <= '0;
      ops_done_q  <= '0;
    end else begin
      if (s2_load) begin
        rsp_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          rsp_p_q  <= prod;
          rsp_id_q <= s1_id_q;
        end
      end
      if (rsp_valid_q && rsp_ready) ops_done_q <= ops_done_q + 1'b1;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_p     = rsp_p_q;
  assign rsp_id    = rsp_id_q;
  assign ops_done  = ops_done_q;
  assign busy      = s1_valid_q || rsp_valid_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Bench for mul_share_arbiter: transaction-queue reference model plus directed literal checks.
`timescale 1ns/1ps
module tb_mul_share_arbiter;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid, req_ready;
  logic [N*32-1:0] req_a, req_b;
  logic            rsp_valid, rsp_ready;
  logic [63:0]     rsp_p;
  logic [1:0]      rsp_id;
  logic            busy;
  logic [15:0]     ops_done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mul_share_arbiter #(
    .NUM_REQ (N),
    .ID_W    (2),
    .CNT_W   (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_p     (rsp_p),
    .rsp_id    (rsp_id),
    .busy      (busy),
    .ops_done  (ops_done)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: in-flight operations oldest first. The oldest one is
  // presented as the response from the cycle after it was issued; at most two
  // are ever in flight, and a third is only taken when the oldest leaves.
  typedef struct {
    logic [63:0] p;
    int          id;
  } txn_t;

  txn_t        q[$];
  bit          shown    = 1'b0;
  int          m_ptr    = 0;
  logic [15:0] m_cnt    = '0;
  logic [N-1:0] last_acc = '0;

  function automatic int scan(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  initial forever begin
    int   g;
    bit   free;
    txn_t t;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      q.delete();
      shown    = 1'b0;
      m_ptr    = 0;
      m_cnt    = '0;
      last_acc = '0;
    end else begin
      g        = scan(req_valid, m_ptr);
      free     = (q.size() < 2) || rsp_ready;
      last_acc = '0;
      if (shown && rsp_ready) begin
        void'(q.pop_front());
        m_cnt = m_cnt + 16'd1;
      end
      shown = (q.size() > 0);
      if (g >= 0 && free) begin
        t.p  = 64'(req_a[g*32 +: 32]) * 64'(req_b[g*32 +: 32]);
        t.id = g;
        q.push_back(t);
        m_ptr       = (g + 1) % N;
        last_acc[g] = 1'b1;
      end
    end
  end

  task automatic compare();
    logic [N-1:0] er;
    int           g;
    er = '0;
    g  = scan(req_valid, m_ptr);
    if (rst_n && g >= 0 && (q.size() < 2 || rsp_ready)) er[g] = 1'b1;
    chk("model req_ready", 64'(req_ready), 64'(er));
    chk("model rsp_valid", 64'(rsp_valid), 64'(shown));
    if (shown) begin
      chk("model rsp_p", rsp_p, q[0].p);
      chk("model rsp_id", 64'(rsp_id), 64'(q[0].id));
    end
    chk("model busy", 64'(busy), 64'(q.size() > 0));
    chk("model ops_done", 64'(ops_done), 64'(m_cnt));
  endtask

  initial forever begin
    @(negedge clk);
    compare();
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_op();
    int unsigned r;
    r = $urandom_range(0, 7);
    if (r == 0) return 32'h0;
    if (r == 1) return 32'hFFFF_FFFF;
    return $urandom;
  endfunction

  initial begin
    int issued;
    int cyc;

    // Reset with every requester asking.
    rst_n     = 1'b0;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset req_ready", 64'(req_ready), 64'h0);
    chk("reset rsp_valid", 64'(rsp_valid), 64'h0);
    chk("reset busy", 64'(busy), 64'h0);
    chk("reset ops_done", 64'(ops_done), 64'h0);
    chk("reset rsp_p", rsp_p, 64'h0);
    chk("reset rsp_id", 64'(rsp_id), 64'h0);
    #1 rst_n = 1'b1;
    #1 chk("first grant", 64'(req_ready), 64'h1);

    // Single op from requester 2 with the widest operands.
    do_reset();
    req_a[95:64] = 32'hFFFF_FFFF;
    req_b[95:64] = 32'hFFFF_FFFF;
    req_valid    = 4'b0100;
    rsp_ready    = 1'b1;
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    chk("single issued not yet valid", 64'(rsp_valid), 64'h0);
    chk("single busy", 64'(busy), 64'h1);
    @(negedge clk);
    chk("single rsp_valid", 64'(rsp_valid), 64'h1);
    chk("single rsp_p", rsp_p, 64'hFFFF_FFFE_0000_0001);
    chk("single rsp_id", 64'(rsp_id), 64'h2);
    @(negedge clk);
    chk("single ops_done", 64'(ops_done), 64'h1);
    chk("single drained", 64'(rsp_valid), 64'h0);

    // Round-robin with everyone continuously valid.
    do_reset();
    req_a     = {32'd4, 32'd3, 32'd2, 32'd1};
    req_b     = {4{32'h10}};
    req_valid = '1;
    rsp_ready = 1'b1;
    #1 chk("rr grant 0", 64'(req_ready), 64'h1);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk("rr grant", 64'(req_ready), 64'(1 << (k % 4)));
      if (k >= 2) begin
        chk("rr rsp_valid", 64'(rsp_valid), 64'h1);
        chk("rr rsp_p", rsp_p, 64'((((k - 2) % 4) + 1) * 16));
        chk("rr rsp_id", 64'(rsp_id), 64'((k - 2) % 4));
      end
    end

    // Backpressure: two requesters, consumer stalled for five cycles.
    do_reset();
    req_a     = {32'd0, 32'd0, 32'd7, 32'd3};
    req_b     = {32'd0, 32'd0, 32'd11, 32'd5};
    req_valid = 4'b0011;
    rsp_ready = 1'b0;
    #1 chk("bp grant 0", 64'(req_ready), 64'h1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("bp req_ready", 64'(req_ready), (k == 1) ? 64'h2 : 64'h0);
      if (k >= 2) begin
        chk("bp held rsp_p", rsp_p, 64'd15);
        chk("bp held rsp_id", 64'(rsp_id), 64'h0);
      end
    end
    @(posedge clk);
    #1;
    req_valid = '0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp drain 0 p", rsp_p, 64'd15);
    @(negedge clk);
    chk("bp drain 1 p", rsp_p, 64'd77);
    chk("bp drain 1 id", 64'(rsp_id), 64'h1);
    @(negedge clk);
    chk("bp drained", 64'(rsp_valid), 64'h0);
    chk("bp ops_done", 64'(ops_done), 64'h2);

    // Asynchronous reset with both stages full.
    do_reset();
    req_valid = 4'b0011;
    rsp_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 chk("mid full busy", 64'(busy), 64'h1);
    rst_n = 1'b0;
    #1;
    chk("mid rst rsp_valid", 64'(rsp_valid), 64'h0);
    chk("mid rst busy", 64'(busy), 64'h0);
    chk("mid rst req_ready", 64'(req_ready), 64'h0);
    req_valid = 4'b1010;
    #1 rst_n = 1'b1;
    #1 chk("mid rst ptr cleared", 64'(req_ready), 64'h2);
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("mid rst no stale rsp", 64'(rsp_valid), 64'h0);
    end

    // Random traffic with random consumer stalls.
    do_reset();
    issued = 0;
    cyc    = 0;
    while ((issued < 1000 || req_valid != '0) && cyc < 20000) begin
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < N; i++) begin
        if (last_acc[i]) req_valid[i] = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && issued < 1000 && $urandom_range(0, 2) == 0) begin
          req_a[i*32 +: 32] = rand_op();
          req_b[i*32 +: 32] = rand_op();
          req_valid[i]      = 1'b1;
          issued++;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    chk("random finished within budget", 64'(cyc < 20000), 64'h1);
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("random ops_done", 64'(ops_done), 64'd1000);
    chk("random idle", 64'(busy), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
